aes_key_sched_ctrl: RTL and testbench

Sequences the single-round key expansion datapath (keygen) to expand an AES-128 cipher key into all 11 round keys, at one round per clock. Stores the round keys in an internal register file and serves them to the encryption round controller through an indexed read port. It sits between key loading (host/config side) and the round pipeline.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_key_sched_ctrl_keygen.sv | 57 +++++
 rtl/aes_key_sched_ctrl.sv | 135 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES-128 key-schedule slice.
//   AES_NR, AES_KEY_W : round count and key/block width
//   aes_block_t       : 128-bit block/key, byte 0 in [127:120], column-major
//   ks_state_t        : key-schedule controller states
//   xtime()           : GF(2^8) multiply-by-2, used to step the round constant
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  typedef logic [AES_KEY_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_READY  = 2'd2
  } ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_keygen.sv
// keygen
// One round of AES-128 key expansion, purely combinational.
//   keyin  [127:0] : previous round key (w0..w3, w0 in [127:96])
//   rcon   [7:0]   : round constant for this round
//   keyout [127:0] : next round key (w4..w7)
module keygen
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] keyin,
  input  logic [7:0]           rcon,
  output logic [AES_KEY_W-1:0] keyout
);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w4, w5, w6, w7;
  logic [31:0] t;

  assign {w0, w1, w2, w3} = keyin;

  // RotWord then SubWord on the last word, round constant into the top byte.
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
  assign w4 = w0 ^ t;
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign keyout = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Expands an AES-128 cipher key into NR+1 round keys, one round per clock,
// and serves them through an indexed read port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_in      : cipher key; key_valid/key_ready handshake
//   clear       : synchronous flush of stored keys, wins over key_valid
//   busy        : expansion in progress
//   keys_valid  : all NR+1 round keys stored and readable
//   rd_idx      : round-key index 0..NR; rd_key : selected round key
//                 (0 when out of range or keys not valid); RD_LAT 0 or 1
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 clear,
  output logic                 busy,
  output logic                 keys_valid,
  input  logic [3:0]           rd_idx,
  output logic [AES_KEY_W-1:0] rd_key
);

  ks_state_t  state;
  logic [3:0] cnt;
  logic [7:0] rcon;
  logic       ready_q;
  logic       busy_q;
  logic       kv_q;
  logic       accept;

  aes_block_t cur;
  aes_block_t nxt;
  aes_block_t rk [0:NR];

  aes_block_t rd_data;
  logic       rd_hit;

  // clear masks the handshake in the same cycle so a key offered alongside
  // a flush is never taken.
  assign key_ready  = ready_q & ~clear;
  assign accept     = key_valid & key_ready;
  assign busy       = busy_q;
  assign keys_valid = kv_q;

  keygen u_keygen (
    .keyin  (cur),
    .rcon   (rcon),
    .keyout (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= KS_IDLE;
      cnt     <= 4'd0;
      rcon    <= 8'h01;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else if (clear) begin
      state   <= KS_IDLE;
      cnt     <= 4'd0;
      rcon    <= 8'h01;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      case (state)
        KS_IDLE, KS_READY: begin
          if (accept) begin
            state   <= KS_EXPAND;
            cnt     <= 4'd1;
            rcon    <= 8'h01;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            kv_q    <= 1'b0;
          end
        end
        KS_EXPAND: begin
          rcon <= xtime(rcon);
          if (cnt == 4'(NR)) begin
            state   <= KS_READY;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            kv_q    <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state   <= KS_IDLE;
          cnt     <= 4'd0;
          rcon    <= 8'h01;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          kv_q    <= 1'b0;
        end
      endcase
    end
  end

  // Round-key storage is never exposed while keys_valid is low, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cur   <= key_in;
      rk[0] <= key_in;
    end else if (state == KS_EXPAND) begin
      cur     <= nxt;
      rk[cnt] <= nxt;
    end
  end

  assign rd_hit  = kv_q && (rd_idx <= 4'(NR));
  assign rd_data = rd_hit ? rk[rd_idx] : '0;

  generate
    if (RD_LAT == 0) begin : g_rd_comb
      assign rd_key = rd_data;
    end else begin : g_rd_reg
      aes_block_t rd_key_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_key_q <= '0;
        else        rd_key_q <= rd_data;
      end
      assign rd_key = rd_key_q;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

  localparam int K_RDKEY = 0;
  localparam int K_KV    = 1;
  localparam int K_KRDY  = 2;
  localparam int K_BUSY  = 3;
  localparam int K_RCON  = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         clear;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  aes_key_sched_ctrl #(.NR(10), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .clear      (clear),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           kind;
    logic [127:0] exp;
    string        name;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  done = 1'b0;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] fips_rk [0:10];
  logic [7:0]   rcon_seq [0:9];

  initial begin
    fips_rk[0]  = K1;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rcon_seq[0] = 8'h01; rcon_seq[1] = 8'h02; rcon_seq[2] = 8'h04;
    rcon_seq[3] = 8'h08; rcon_seq[4] = 8'h10; rcon_seq[5] = 8'h20;
    rcon_seq[6] = 8'h40; rcon_seq[7] = 8'h80; rcon_seq[8] = 8'h1b;
    rcon_seq[9] = 8'h36;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [127:0] sample(input int kind);
    case (kind)
      K_RDKEY: return rd_key;
      K_KV:    return {127'd0, keys_valid};
      K_KRDY:  return {127'd0, key_ready};
      K_BUSY:  return {127'd0, busy};
      default: return {120'd0, dut.rcon};
    endcase
  endfunction

  // Monitor: at every falling edge, compare all entries due this cycle.
  initial forever begin
    @(negedge clk);
    begin
      int i;
      logic [127:0] act;
      i = 0;
      while (i < sbq.size()) begin
        if (sbq[i].cyc <= cyc) begin
          act = sample(sbq[i].kind);
          n_checks = n_checks + 1;
          if (sbq[i].cyc != cyc || act !== sbq[i].exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cyc %0d (due %0d): got %h, expected %h",
                     sbq[i].name, cyc, sbq[i].cyc, act, sbq[i].exp);
          end
          sbq.delete(i);
        end else begin
          i = i + 1;
        end
      end
    end
  end

  task automatic push(input int tgt, input int kind, input logic [127:0] e, input string nm);
    sb_t it;
    it.cyc  = tgt;
    it.kind = kind;
    it.exp  = e;
    it.name = nm;
    sbq.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_key(input logic [127:0] k, output int t);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    t = cyc;
  endtask

  task automatic expand_checks(input int t, input bit rc);
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) begin
        push(t, K_BUSY, 128'd1, "busy_start");
        push(t, K_KRDY, 128'd0, "key_ready_start");
        push(t, K_KV,   128'd0, "keys_valid_start");
      end
      if (k == 5) begin
        push(t + k, K_KRDY, 128'd0, "key_ready_mid");
        push(t + k, K_BUSY, 128'd1, "busy_mid");
      end
      if (k == 9) push(t + k, K_KV, 128'd0, "keys_valid_t9");
      if (k == 10) begin
        push(t + k, K_KV,   128'd1, "keys_valid_t10");
        push(t + k, K_BUSY, 128'd0, "busy_t10");
        push(t + k, K_KRDY, 128'd1, "key_ready_t10");
      end
      if (rc && k <= 9) push(t + k, K_RCON, {120'd0, rcon_seq[k]}, "rcon_step");
    end
  endtask

  task automatic read_chk(input logic [3:0] idx, input logic [127:0] e, input string nm);
    rd_idx = idx;
    push(cyc + 1, K_RDKEY, e, nm);
    tick();
  endtask

  initial begin
    int t;
    int t2;
    rst_n     = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    clear     = 1'b0;
    rd_idx    = 4'd0;

    // Reset state
    ticks(2);
    push(cyc, K_KRDY,  128'd1, "rst_key_ready");
    push(cyc, K_BUSY,  128'd0, "rst_busy");
    push(cyc, K_KV,    128'd0, "rst_keys_valid");
    push(cyc, K_RDKEY, 128'd0, "rst_rd_key");
    push(cyc, K_RCON,  128'h01, "rst_rcon");
    tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 key, then reads including out-of-range and back-to-back
    load_key(K1, t);
    expand_checks(t, 1'b0);
    ticks(10);
    read_chk(4'd1,  fips_rk[1],  "fips_rk1");
    read_chk(4'd10, fips_rk[10], "fips_rk10");
    read_chk(4'd0,  fips_rk[0],  "fips_rk0");
    for (int i = 11; i <= 15; i++) read_chk(4'(i), 128'd0, "rd_out_of_range");
    for (int i = 0; i <= 10; i++) read_chk(4'(i), fips_rk[i], "rd_b2b");

    // Second key with rcon probe
    load_key(K2, t);
    expand_checks(t, 1'b1);
    ticks(10);
    read_chk(4'd10, K2R10, "k2_rk10");
    read_chk(4'd0,  K2,    "k2_rk0");

    // clear together with key_valid in READY
    read_chk(4'd10, K2R10, "pre_clear_rk10");
    clear     = 1'b1;
    key_valid = 1'b1;
    key_in    = K1;
    push(cyc,     K_KRDY,  128'd0, "clear_masks_ready");
    push(cyc + 1, K_RDKEY, K2R10,  "clear_edge_rd");
    tick();
    clear     = 1'b0;
    key_valid = 1'b0;
    push(cyc,     K_KV,    128'd0, "clear_keys_valid");
    push(cyc,     K_BUSY,  128'd0, "clear_busy");
    push(cyc,     K_KRDY,  128'd1, "clear_idle_ready");
    push(cyc + 1, K_RDKEY, 128'd0, "clear_rd_key");
    push(cyc + 1, K_BUSY,  128'd0, "clear_not_accepted");
    ticks(2);

    // Asynchronous reset pulse mid-expansion, released before the next edge
    load_key(K1, t);
    push(t, K_BUSY, 128'd1, "busy_pre_reset");
    ticks(5);
    rst_n = 1'b0;
    push(cyc, K_KRDY,  128'd1, "async_rst_key_ready");
    push(cyc, K_BUSY,  128'd0, "async_rst_busy");
    push(cyc, K_KV,    128'd0, "async_rst_keys_valid");
    push(cyc, K_RDKEY, 128'd0, "async_rst_rd_key");
    push(cyc, K_RCON,  128'h01, "async_rst_rcon");
    #2;
    rst_n = 1'b1;
    tick();
    push(cyc, K_KRDY, 128'd1, "post_rst_idle");
    push(cyc, K_KV,   128'd0, "post_rst_keys_valid");
    load_key(K2, t);
    expand_checks(t, 1'b0);
    ticks(10);
    read_chk(4'd10, K2R10, "post_rst_rk10");
    read_chk(4'd0,  K2,    "post_rst_rk0");

    // key_valid held through EXPAND with a second key
    key_in    = K1;
    key_valid = 1'b1;
    tick();
    t = cyc;
    key_in = K2;
    expand_checks(t, 1'b0);
    ticks(10);
    rd_idx = 4'd1;
    push(cyc + 1, K_KV,    128'd0,     "held_accept_kv_drop");
    push(cyc + 1, K_BUSY,  128'd1,     "held_accept_busy");
    push(cyc + 1, K_RDKEY, fips_rk[1], "held_edge_rd");
    push(cyc + 2, K_RDKEY, 128'd0,     "old_keys_hidden");
    tick();
    key_valid = 1'b0;
    t2 = cyc;
    expand_checks(t2, 1'b0);
    ticks(10);
    read_chk(4'd10, K2R10, "held_k2_rk10");
    read_chk(4'd0,  K2,    "held_k2_rk0");

    ticks(3);
    if (sbq.size() != 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    done = 1'b1;
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
    end
  end

endmodule
